// File: rtl/uart_job_controller_if.sv
// Signal bundle between the UART byte core / SHA-256 miner and the job controller.
// The controller uses the slave view; the surrounding fabric (or a bench) uses master.
interface uart_job_controller_if #(
  parameter int HEADER_BYTES = 80
);
  logic [7:0]                  rx_data;
  logic                        rx_rdy;
  logic                        rx_rdy_clr;
  logic [7:0]                  tx_data;
  logic                        tx_wr_en;
  logic                        tx_busy;
  logic [8*HEADER_BYTES-1:0]   header_data;
  logic                        miner_start;
  logic                        nonce_found;
  logic [31:0]                 nonce_in;
  logic                        nonce_dropped;
  logic                        frame_dropped;
  logic [6:0]                  byte_count;

  modport slave (
    input  rx_data, rx_rdy, tx_busy, nonce_found, nonce_in,
    output rx_rdy_clr, tx_data, tx_wr_en, header_data, miner_start,
           nonce_dropped, frame_dropped, byte_count
  );

  modport master (
    output rx_data, rx_rdy, tx_busy, nonce_found, nonce_in,
    input  rx_rdy_clr, tx_data, tx_wr_en, header_data, miner_start,
           nonce_dropped, frame_dropped, byte_count
  );
endinterface

// File: rtl/uart_job_controller.sv
// UART job controller: assembles received bytes into a block header for the miner,
// and serialises found nonces MSB-first to the UART transmitter (active + 1 pending).
module uart_job_controller #(
  parameter int HEADER_BYTES = 80,
  parameter int NONCE_BYTES  = 4,
  parameter int RX_TIMEOUT   = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_job_controller_if.slave  bus
);
  localparam int HW = 8 * HEADER_BYTES;
  localparam int IW = $clog2(RX_TIMEOUT + 1);
  localparam int BW = $clog2(NONCE_BYTES + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;

  // Receive path state
  logic [HW-1:0] shift_q, shift_d;
  logic [HW-1:0] header_q, header_d;
  logic [6:0]    byte_count_q, byte_count_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          rx_rdy_clr_q, rx_rdy_clr_d;
  logic          commit_q, commit_d;
  logic          miner_start_q, miner_start_d;
  logic          frame_dropped_q, frame_dropped_d;
  logic          capture;

  // Transmit path state
  tx_state_t     state_q, state_d;
  logic [31:0]   active_q, active_d;
  logic          active_valid_q, active_valid_d;
  logic [31:0]   pending_q, pending_d;
  logic          pending_valid_q, pending_valid_d;
  logic [BW-1:0] bytes_left_q, bytes_left_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_wr_en_q, tx_wr_en_d;
  logic          nonce_dropped_q, nonce_dropped_d;

  // RX: capture one byte per rx_rdy, commit a full frame one clock later, drop stale partials
  always_comb begin
    // The acknowledge is still high while the core clears rx_rdy, so it masks re-capture.
    capture         = bus.rx_rdy && !rx_rdy_clr_q;
    shift_d         = shift_q;
    header_d        = header_q;
    byte_count_d    = byte_count_q;
    idle_d          = idle_q;
    rx_rdy_clr_d    = capture;
    commit_d        = 1'b0;
    miner_start_d   = commit_q;
    frame_dropped_d = 1'b0;
    if (commit_q) begin
      header_d = shift_q;
    end
    if (capture) begin
      shift_d = {shift_q[HW-9:0], bus.rx_data};
      idle_d  = '0;
      if (byte_count_q == 7'(HEADER_BYTES - 1)) begin
        byte_count_d = '0;
        commit_d     = 1'b1;
      end else begin
        byte_count_d = byte_count_q + 7'd1;
      end
    end else if (byte_count_q != 7'd0) begin
      if (idle_q == IW'(RX_TIMEOUT - 1)) begin
        byte_count_d    = '0;
        shift_d         = '0;
        idle_d          = '0;
        frame_dropped_d = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  // RX state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q         <= '0;
      header_q        <= '0;
      byte_count_q    <= '0;
      idle_q          <= '0;
      rx_rdy_clr_q    <= 1'b0;
      commit_q        <= 1'b0;
      miner_start_q   <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      shift_q         <= shift_d;
      header_q        <= header_d;
      byte_count_q    <= byte_count_d;
      idle_q          <= idle_d;
      rx_rdy_clr_q    <= rx_rdy_clr_d;
      commit_q        <= commit_d;
      miner_start_q   <= miner_start_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  // TX: byte sequencer plus nonce buffering (promotion is resolved before a new nonce lands)
  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    active_valid_d  = active_valid_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    bytes_left_d    = bytes_left_q;
    tx_data_d       = tx_data_q;
    tx_wr_en_d      = 1'b0;
    nonce_dropped_d = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (active_valid_q) begin
          state_d      = TX_LOAD;
          bytes_left_d = BW'(NONCE_BYTES);
        end else if (pending_valid_q) begin
          active_d        = pending_q;
          active_valid_d  = 1'b1;
          pending_valid_d = 1'b0;
        end
      end
      TX_LOAD: begin
        // Only strobe into an idle transmitter.
        if (!bus.tx_busy) begin
          tx_data_d    = active_q[31:24];
          tx_wr_en_d   = 1'b1;
          active_d     = {active_q[23:0], 8'h00};
          bytes_left_d = bytes_left_q - BW'(1);
          state_d      = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: begin
        if (bus.tx_busy) state_d = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (bytes_left_q != '0) begin
            state_d = TX_LOAD;
          end else begin
            state_d         = TX_IDLE;
            active_d        = pending_q;
            active_valid_d  = pending_valid_q;
            pending_valid_d = 1'b0;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (bus.nonce_found) begin
      if (state_q == TX_IDLE && !active_valid_d) begin
        active_d       = bus.nonce_in;
        active_valid_d = 1'b1;
      end else if (!pending_valid_d) begin
        pending_d       = bus.nonce_in;
        pending_valid_d = 1'b1;
      end else begin
        nonce_dropped_d = 1'b1;
      end
    end
  end

  // TX state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= TX_IDLE;
      active_q        <= '0;
      active_valid_q  <= 1'b0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      bytes_left_q    <= '0;
      tx_data_q       <= '0;
      tx_wr_en_q      <= 1'b0;
      nonce_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      active_valid_q  <= active_valid_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      bytes_left_q    <= bytes_left_d;
      tx_data_q       <= tx_data_d;
      tx_wr_en_q      <= tx_wr_en_d;
      nonce_dropped_q <= nonce_dropped_d;
    end
  end

  assign bus.rx_rdy_clr    = rx_rdy_clr_q;
  assign bus.header_data   = header_q;
  assign bus.byte_count    = byte_count_q;
  assign bus.miner_start   = miner_start_q;
  assign bus.frame_dropped = frame_dropped_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_wr_en      = tx_wr_en_q;
  assign bus.nonce_dropped = nonce_dropped_q;
endmodule

// File: tb/tb_uart_job_controller.sv
// Bench for uart_job_controller: byte-queue reference model, UART transmitter model,
// per-cycle output comparison and directed/random scenarios.
module tb_uart_job_controller;
  localparam int HB        = 80;
  localparam int HW        = 8 * HB;
  localparam int TO        = 64;
  localparam int BUSY_CLKS = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_job_controller_if #(.HEADER_BYTES(HB)) bus();

  uart_job_controller #(.HEADER_BYTES(HB), .NONCE_BYTES(4), .RX_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- reference model (advances on each clock edge) ----------------
  logic [7:0]    frame[$];
  logic [31:0]   held[$];
  logic [31:0]   accepted[$];
  int            m_idle, released;
  logic          m_cap, m_ack, m_start, m_fdrop, m_commit, m_ndrop;
  logic [HW-1:0] m_header, m_hdr_next;

  // ---------------- UART transmitter model / observation ----------------
  logic [7:0]    tx_log[$];
  int            widx, done_tx, busy_cnt;
  int            mstart_cnt = 0, fdrop_cnt = 0, ack_cnt = 0, ndrop_cnt = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame.delete(); held.delete(); accepted.delete();
      m_idle = 0; released = 0; m_cap = 0; m_ack = 0; m_start = 0;
      m_fdrop = 0; m_commit = 0; m_ndrop = 0; m_header = '0; m_hdr_next = '0;
    end else begin
      m_cap   = bus.rx_rdy && !m_ack;
      m_start = m_commit;
      if (m_commit) m_header = m_hdr_next;
      m_commit = 0;
      m_fdrop  = 0;
      if (m_cap) begin
        frame.push_back(bus.rx_data);
        m_idle = 0;
        if (frame.size() == HB) begin
          m_hdr_next = '0;
          foreach (frame[i]) m_hdr_next = {m_hdr_next[HW-9:0], frame[i]};
          m_commit = 1;
          frame.delete();
        end
      end else if (frame.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          frame.delete();
          m_idle  = 0;
          m_fdrop = 1;
        end
      end else begin
        m_idle = 0;
      end
      m_ack = m_cap;
      // A nonce occupies a slot until its last byte has left the transmitter.
      m_ndrop = 0;
      if (done_tx > released && !bus.tx_busy) begin
        held.delete(0);
        released++;
      end
      if (bus.nonce_found) begin
        if (held.size() < 2) begin
          held.push_back(bus.nonce_in);
          accepted.push_back(bus.nonce_in);
        end else begin
          m_ndrop = 1;
        end
      end
    end
  end

  // Compare DUT against model every cycle, then play the UART transmitter
  always @(negedge clock) begin
    logic [31:0] w;
    if (!reset) begin
      bus.tx_busy = 1'b0;
      busy_cnt = 0; widx = 0; done_tx = 0;
    end else begin
      check("rx_rdy_clr", HW'(bus.rx_rdy_clr), HW'(m_ack));
      check("byte_count", HW'(bus.byte_count), HW'(frame.size()));
      check("miner_start", HW'(bus.miner_start), HW'(m_start));
      check("frame_dropped", HW'(bus.frame_dropped), HW'(m_fdrop));
      check("header_data", bus.header_data, m_header);
      check("nonce_dropped", HW'(bus.nonce_dropped), HW'(m_ndrop));
      if (bus.miner_start) mstart_cnt++;
      if (bus.frame_dropped) fdrop_cnt++;
      if (bus.rx_rdy_clr) ack_cnt++;
      if (bus.nonce_dropped) ndrop_cnt++;
      if (bus.tx_wr_en) check("wr_while_busy", HW'(bus.tx_busy), HW'(0));
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
      end
      if (bus.tx_wr_en) begin
        if (widx / 4 < accepted.size()) begin
          w = accepted[widx / 4] >> (8 * (3 - widx % 4));
          check("tx_byte", HW'(bus.tx_data), HW'(w[7:0]));
        end else begin
          check("tx_unexpected_write", HW'(widx / 4), HW'(accepted.size()));
        end
        tx_log.push_back(bus.tx_data);
        widx++;
        if (widx % 4 == 0) done_tx++;
        busy_cnt    = BUSY_CLKS;
        bus.tx_busy = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap, input bit last);
    bit seen = 0;
    @(negedge clock);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.rx_rdy_clr) begin seen = 1; break; end
    end
    check("rx_ack_seen", HW'(seen), HW'(1));
    if (last) check("start_not_early", HW'(bus.miner_start), HW'(0));
    // rx_rdy stays high through the acknowledge cycle, like the real core.
    @(negedge clock);
    bus.rx_rdy = 1'b0;
    if (last) check("start_1clk_after", HW'(bus.miner_start), HW'(1));
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_nonce(input logic [31:0] n);
    @(negedge clock);
    bus.nonce_in    = n;
    bus.nonce_found = 1'b1;
    @(negedge clock);
    bus.nonce_found = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int i = 0;
    while (tx_log.size() < n && i < 3000) begin @(negedge clock); i++; end
    check("tx_log_wait", HW'(tx_log.size() >= n), HW'(1));
  endtask

  task automatic wait_tx_idle();
    int  i = 0;
    bit  idle = 0;
    while (!idle && i < 3000) begin
      @(negedge clock);
      idle = (widx == 4 * accepted.size()) && !bus.tx_busy;
      i++;
    end
    check("tx_idle_wait", HW'(idle), HW'(1));
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_rx_rdy_clr", HW'(bus.rx_rdy_clr), HW'(0));
    check("rst_tx_wr_en", HW'(bus.tx_wr_en), HW'(0));
    check("rst_tx_data", HW'(bus.tx_data), HW'(0));
    check("rst_header", bus.header_data, HW'(0));
    check("rst_miner_start", HW'(bus.miner_start), HW'(0));
    check("rst_byte_count", HW'(bus.byte_count), HW'(0));
    check("rst_drops", HW'({bus.nonce_dropped, bus.frame_dropped}), HW'(0));
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [HW-1:0] hdr;
    logic [7:0]    b;
    int base, ms0, fd0, ack0, nd0;
    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.nonce_found = 1'b0; bus.nonce_in = '0;
    do_reset();

    // 1: header 0x00..0x4F
    ms0 = mstart_cnt; ack0 = ack_cnt; hdr = '0;
    for (int i = 0; i < HB; i++) begin
      send_byte(8'(i), 10, i == HB - 1);
      hdr = {hdr[HW-9:0], 8'(i)};
    end
    repeat (3) @(negedge clock);
    check("t1_starts", HW'(mstart_cnt - ms0), HW'(1));
    check("t1_acks", HW'(ack_cnt - ack0), HW'(80));
    check("t1_top_byte", HW'(bus.header_data[HW-1:HW-8]), HW'(8'h00));
    check("t1_low_byte", HW'(bus.header_data[7:0]), HW'(8'h4F));
    check("t1_byte_count", HW'(bus.byte_count), HW'(0));

    // 2: partial frame times out, header unchanged, then a clean frame
    ms0 = mstart_cnt; fd0 = fdrop_cnt;
    for (int i = 0; i < 40; i++) send_byte(8'($urandom), 2, 1'b0);
    repeat (TO + 20) @(negedge clock);
    check("t2_frame_dropped", HW'(fdrop_cnt - fd0), HW'(1));
    check("t2_byte_count", HW'(bus.byte_count), HW'(0));
    check("t2_header_kept", bus.header_data, hdr);
    check("t2_no_start", HW'(mstart_cnt - ms0), HW'(0));
    hdr = '0;
    for (int i = 0; i < HB; i++) begin
      b = 8'(i) ^ 8'h5A;
      send_byte(b, 1, i == HB - 1);
      hdr = {hdr[HW-9:0], b};
    end
    repeat (3) @(negedge clock);
    check("t2_new_header", bus.header_data, hdr);
    check("t2_start", HW'(mstart_cnt - ms0), HW'(1));

    // 3: single nonce, MSB first
    base = tx_log.size();
    send_nonce(32'hDEADBEEF);
    wait_log(base + 4);
    wait_tx_idle();
    check("t3_b0", HW'(tx_log[base]), HW'(8'hDE));
    check("t3_b1", HW'(tx_log[base + 1]), HW'(8'hAD));
    check("t3_b2", HW'(tx_log[base + 2]), HW'(8'hBE));
    check("t3_b3", HW'(tx_log[base + 3]), HW'(8'hEF));

    // 4: three nonces 2 clk apart -> third dropped
    base = tx_log.size(); nd0 = ndrop_cnt;
    send_nonce(32'h11111111);
    send_nonce(32'h22222222);
    send_nonce(32'h33333333);
    wait_log(base + 8);
    wait_tx_idle();
    check("t4_first", HW'(tx_log[base]), HW'(8'h11));
    check("t4_second", HW'(tx_log[base + 4]), HW'(8'h22));
    check("t4_total", HW'(tx_log.size() - base), HW'(8));
    check("t4_dropped", HW'(ndrop_cnt - nd0), HW'(1));

    // 5: reset mid-header and mid-nonce, then recover
    for (int i = 0; i < 30; i++) send_byte(8'($urandom), 1, 1'b0);
    do_reset();
    check("t5_count_cleared", HW'(bus.byte_count), HW'(0));
    base = tx_log.size();
    send_nonce(32'h0BADF00D);
    wait_log(base + 2);
    do_reset();
    ms0 = mstart_cnt; hdr = '0;
    for (int i = 0; i < HB; i++) begin
      b = 8'($urandom);
      send_byte(b, 0, i == HB - 1);
      hdr = {hdr[HW-9:0], b};
    end
    repeat (3) @(negedge clock);
    check("t5_header", bus.header_data, hdr);
    check("t5_start", HW'(mstart_cnt - ms0), HW'(1));
    base = tx_log.size();
    send_nonce(32'hCAFEF00D);
    wait_log(base + 4);
    wait_tx_idle();
    check("t5_nonce", HW'({tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]}),
          HW'(32'hCAFEF00D));

    // Random traffic on both paths at once; the per-cycle model does the checking.
    fork
      begin
        for (int f = 0; f < 2; f++)
          for (int i = 0; i < HB; i++) send_byte(8'($urandom), $urandom_range(0, 8), 1'b0);
        for (int i = 0; i < 25; i++) send_byte(8'($urandom), $urandom_range(0, 8), 1'b0);
        repeat (TO + 10) @(negedge clock);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ($urandom_range(1, 60)) @(negedge clock);
          send_nonce($urandom);
        end
      end
    join
    wait_tx_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
